// File: rtl/err_inj_pkg.sv
// Shared types and constants for the error-injection controller.
package err_inj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  localparam logic        OP_OR      = 1'b0;
  localparam logic        OP_XOR     = 1'b1;
  localparam logic        MODE_FIXED = 1'b0;
  localparam logic        MODE_RAND  = 1'b1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/err_mask_gen.sv
// Random K-bit mask builder: free-running LFSR plus one-candidate-per-cycle
// bit setter. mask/done are combinational so the caller can register the
// finished mask on the same edge the last bit lands.
module err_mask_gen
  import err_inj_pkg::*;
#(
  parameter int          N    = 8,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int         IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [IW:0]   k,
  output logic [N-1:0]  mask,
  output logic          done
);

  localparam int NP = 1 << IW;

  logic [15:0]   lfsr_q;
  logic [N-1:0]  mask_q;
  logic [IW:0]   rem_q;
  logic          busy_q;

  logic [IW-1:0] idx;
  logic [NP-1:0] mask_ext;
  logic [NP-1:0] oh;
  logic          hit;

  // candidate index from the LFSR; accept only in-range, not-yet-set bits
  always_comb begin
    idx           = lfsr_q[IW-1:0];
    mask_ext      = '0;
    mask_ext[N-1:0] = mask_q;
    oh            = {{(NP-1){1'b0}}, 1'b1} << idx;
    hit           = busy_q && ({1'b0, idx} < (IW+1)'(N)) && !mask_ext[idx];
    mask          = mask_q | (hit ? oh[N-1:0] : '0);
    done          = hit && (rem_q == (IW+1)'(1));
  end

  // LFSR runs every cycle; build state restarts on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      mask_q <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (start) begin
        mask_q <= '0;
        rem_q  <= k;
        busy_q <= (k != '0);
      end else if (hit) begin
        mask_q <= mask;
        rem_q  <= rem_q - 1'b1;
        if (done) busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/err_inject_ctrl.sv
// Error-injection sequencer: accepts a word, decides whether it is corrupted
// (every P-th word), builds a fixed or random K-bit mask, applies it with
// OR/XOR and emits the result. One word in flight at a time.
// Optional: define ERR_INJ_FORCE_EN to add force_inj, which forces injection
// on the accept cycle without advancing the period counter.
module err_inject_ctrl
  import err_inj_pkg::*;
#(
  parameter int          N    = 8,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int         IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef ERR_INJ_FORCE_EN
  input  logic          force_inj,
`endif
  input  logic          cfg_mode,
  input  logic          cfg_op,
  input  logic [IW:0]   cfg_nerr,
  input  logic [N-1:0]  cfg_mask,
  input  logic [7:0]    cfg_period,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [N-1:0]  out_mask,
  output logic [15:0]   inj_cnt
);

  state_e        state_q, state_d;
  logic [7:0]    pcnt_q, pcnt_d, p_eff;
  logic [N-1:0]  data_q;
  logic          op_q;
  logic          frc, at_wrap, inject, accept, rand_go;
  logic [IW:0]   kk;
  logic [N-1:0]  fix_mask, gen_mask;
  logic          gen_done;

  function automatic logic [N-1:0] apply(input logic [N-1:0] d, input logic [N-1:0] m,
                                         input logic op);
    return (op == OP_XOR) ? (d ^ m) : (d | m);
  endfunction

`ifdef ERR_INJ_FORCE_EN
  assign frc = force_inj;
`else
  assign frc = 1'b0;
`endif

  // accept-cycle decisions: inject flag, period counter, clamped K, mask source
  always_comb begin
    p_eff    = (cfg_period == 8'd0) ? 8'd1 : cfg_period;
    // >= rather than == so a shrunk period cannot strand the counter above P-1
    at_wrap  = (pcnt_q >= p_eff - 8'd1);
    inject   = frc || at_wrap;
    pcnt_d   = frc ? pcnt_q : (at_wrap ? 8'd0 : pcnt_q + 8'd1);
    kk       = (cfg_nerr > (IW+1)'(N)) ? (IW+1)'(N) : cfg_nerr;
    accept   = in_valid && in_ready;
    rand_go  = accept && inject && (cfg_mode == MODE_RAND) && (kk != '0);
    fix_mask = (inject && (cfg_mode == MODE_FIXED)) ? cfg_mask : '0;
  end

  err_mask_gen #(.N(N), .SEED(SEED)) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .start (rand_go),
    .k     (kk),
    .mask  (gen_mask),
    .done  (gen_done)
  );

  // state register; in_ready registered so it reads 0 while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == IDLE);
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = rand_go ? BUILD : OUT;
      BUILD:   if (gen_done)  state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    out_valid = (state_q == OUT);
  end

  // word/config capture, output registers and injection statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= 8'd0;
      data_q   <= '0;
      op_q     <= 1'b0;
      out_data <= '0;
      out_mask <= '0;
      inj_cnt  <= 16'd0;
    end else begin
      if (accept) begin
        pcnt_q   <= pcnt_d;
        data_q   <= in_data;
        op_q     <= cfg_op;
        out_mask <= fix_mask;
        out_data <= apply(in_data, fix_mask, cfg_op);
      end else if ((state_q == BUILD) && gen_done) begin
        out_mask <= gen_mask;
        out_data <= apply(data_q, gen_mask, op_q);
      end
      if (out_valid && out_ready && (out_mask != '0) && (inj_cnt != 16'hFFFF))
        inj_cnt <= inj_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_err_inject_ctrl.sv
// Directed bench for err_inject_ctrl (N=8, default build).
module tb_err_inject_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_mode, cfg_op;
  logic [3:0] cfg_nerr;
  logic [7:0] cfg_mask, cfg_period;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data, out_mask;
  logic [15:0] inj_cnt;

  always #5 clk = ~clk;

  err_inject_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_op(cfg_op), .cfg_nerr(cfg_nerr),
    .cfg_mask(cfg_mask), .cfg_period(cfg_period),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .inj_cnt(inj_cnt)
  );

  // driver -> checker side channel (literal expectations, phase, timeouts)
  bit         lit_en;
  logic [7:0] lit_d, lit_m;
  int         lit_c;
  int         phase;
  int         to_cnt;
  bit         fin;

  typedef struct {
    logic [7:0] data, mask;
    logic       mode, op, inj, build;
    int         kk, acc_cyc;
    bit         lit;
    logic [7:0] ld, lm;
    int         lc;
  } ent_t;

  // ---------------- checker / model ----------------
  int checks = 0, errors = 0;
  int cyc = 0, since = 0, wsr = 0, exp_cnt = 0, to_seen = 0;
  int rcnt = 0, rep_cmp = 0, same_pairs = 0, rand_seen = 0;
  bit fin_done = 0, hold = 0, prev_hs = 0, have_last = 0;
  logic [7:0] hd, hm, last_rm;
  logic [7:0] rec [64];
  ent_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    int   p;
    bit   pending;
    logic [7:0] em;
    cyc++;
    if (to_cnt != to_seen) begin
      to_seen++;
      chk("handshake timeout", 32'd1, 32'd0);
    end
    if (!rst_n) begin
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready",  32'(in_ready),  32'd0);
      chk("reset out_data",  32'(out_data),  32'd0);
      chk("reset out_mask",  32'(out_mask),  32'd0);
      chk("reset inj_cnt",   32'(inj_cnt),   32'd0);
      sb.delete();
      since = 0; wsr = 0; exp_cnt = 0; rcnt = 0;
      hold = 0; prev_hs = 0; have_last = 0;
    end else begin
      if (since >= 1) begin
        pending = (sb.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(!pending));
        if (!pending) chk("spurious out_valid", 32'(out_valid), 32'd0);
        else begin
          e = sb[0];
          if (!e.build && cyc == e.acc_cyc + 1)
            chk("fixed-path latency", 32'(out_valid), 32'd1);
          if (e.build && cyc < e.acc_cyc + 1 + e.kk)
            chk("build min latency", 32'(out_valid), 32'd0);
        end
        if (prev_hs) chk("single transfer", 32'(out_valid), 32'd0);
        if (hold) begin
          chk("held out_valid", 32'(out_valid), 32'd1);
          chk("held out_data",  32'(out_data),  32'(hd));
          chk("held out_mask",  32'(out_mask),  32'(hm));
        end
        chk("inj_cnt", 32'(inj_cnt), 32'(exp_cnt));
        prev_hs = 0; hold = 0;
        if (out_valid && pending) begin
          if (out_ready) begin
            e = sb.pop_front();
            prev_hs = 1;
            if (!e.inj || (e.mode && e.kk == 0)) begin
              chk("clean mask", 32'(out_mask), 32'd0);
              chk("clean data", 32'(out_data), 32'(e.data));
            end else if (!e.mode) begin
              em = e.mask;
              chk("fixed mask", 32'(out_mask), 32'(em));
              chk("fixed data", 32'(out_data), 32'(e.op ? (e.data ^ em) : (e.data | em)));
            end else begin
              chk("rand popcount", 32'($countones(out_mask)), 32'(e.kk));
              chk("rand data", 32'(out_data),
                  32'(e.op ? (e.data ^ out_mask) : (e.data | out_mask)));
              rand_seen++;
              if (have_last && out_mask == last_rm) same_pairs++;
              last_rm = out_mask; have_last = 1;
              if (rcnt < 64) begin
                if (phase == 1) rec[rcnt] = out_mask;
                if (phase == 2) begin
                  chk("repeat-after-reset mask", 32'(out_mask), 32'(rec[rcnt]));
                  rep_cmp++;
                end
                rcnt++;
              end
            end
            if (e.lit) begin
              chk("vector out_data", 32'(out_data), 32'(e.ld));
              chk("vector out_mask", 32'(out_mask), 32'(e.lm));
              if (e.lc >= 0) chk("vector inj_cnt", 32'(inj_cnt), 32'(e.lc));
            end
            if (e.inj && (e.mode ? (e.kk > 0) : (e.mask != 8'h00)) && exp_cnt < 65535)
              exp_cnt++;
          end else begin
            hold = 1; hd = out_data; hm = out_mask;
          end
        end
      end
      // record an accept happening at the coming edge
      if (in_valid && in_ready) begin
        wsr++;
        p = (cfg_period == 8'd0) ? 1 : int'(cfg_period);
        e.data = in_data; e.mask = cfg_mask; e.mode = cfg_mode; e.op = cfg_op;
        e.inj  = (p <= 1) || (wsr % p == 0);
        e.kk   = (int'(cfg_nerr) > N) ? N : int'(cfg_nerr);
        e.build = e.inj && cfg_mode && (e.kk > 0);
        e.acc_cyc = cyc;
        e.lit = lit_en; e.ld = lit_d; e.lm = lit_m; e.lc = lit_c;
        sb.push_back(e);
      end
      since++;
    end
    if (fin && !fin_done) begin
      fin_done = 1;
      chk("random words seen >= 1000", 32'(rand_seen >= 1000), 32'd1);
      chk("few identical consecutive masks", 32'(same_pairs < 100), 32'd1);
      chk("repeat masks compared", 32'(rep_cmp), 32'd4);
    end
  end

  // ---------------- driver ----------------
  task automatic rel_reset;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rel_reset();
  endtask

  // present a word and return just after the accepting edge
  task automatic present(input logic m, input logic o, input logic [3:0] k,
                         input logic [7:0] msk, input logic [7:0] d,
                         input bit le, input logic [7:0] ld, input logic [7:0] lm,
                         input int lc);
    int n;
    cfg_mode = m; cfg_op = o; cfg_nerr = k; cfg_mask = msk; in_data = d;
    lit_en = le; lit_d = ld; lit_m = lm; lit_c = lc;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) begin to_cnt++; @(posedge clk); #1 in_valid = 1'b0; return; end
    @(posedge clk); #1;
    // scramble config after accept: the word in flight must not see it
    in_valid = 1'b0; cfg_mode = ~m; cfg_op = ~o; cfg_nerr = k + 4'd3;
    cfg_mask = ~msk; in_data = ~d; lit_en = 0;
  endtask

  task automatic send(input logic m, input logic o, input logic [3:0] k,
                      input logic [7:0] msk, input logic [7:0] d,
                      input bit le, input logic [7:0] ld, input logic [7:0] lm,
                      input int lc, input int bp);
    int n;
    out_ready = (bp == 0);
    present(m, o, k, msk, d, le, ld, lm, lc);
    if (bp != 0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 500);
      if (!out_valid) to_cnt++;
      repeat (bp) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_ready) && n < 500);
    if (!(out_valid && out_ready)) to_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b1; in_valid = 0; out_ready = 1; cfg_mode = 0; cfg_op = 0;
    cfg_nerr = 0; cfg_mask = 0; cfg_period = 8'd1; in_data = 0;
    lit_en = 0; lit_d = 0; lit_m = 0; lit_c = -1; phase = 0; to_cnt = 0; fin = 0;
    #2 rst_n = 1'b0;
    rel_reset();

    // fixed/XOR/zero-mask/K>N/K=0 cases, every word injected
    send(0, 0, 4'd0,  8'h81, 8'h10, 1, 8'h91, 8'h81, 0, 0);
    send(0, 1, 4'd0,  8'hFF, 8'h5A, 1, 8'hA5, 8'hFF, 1, 0);
    send(0, 0, 4'd0,  8'h00, 8'h3C, 1, 8'h3C, 8'h00, 2, 0);
    send(1, 1, 4'd15, 8'h00, 8'h0F, 1, 8'hF0, 8'hFF, 2, 0);
    send(1, 0, 4'd0,  8'hAA, 8'h77, 1, 8'h77, 8'h00, 3, 0);
    send(0, 1, 4'd0,  8'h00, 8'hC3, 1, 8'hC3, 8'h00, 3, 0);
    // backpressure: output held 10 cycles
    send(0, 1, 4'd0,  8'h0F, 8'h33, 1, 8'h3C, 8'h0F, 3, 10);
    send(1, 1, 4'd3,  8'h00, 8'h55, 0, 8'h00, 8'h00, -1, 10);

    // period 4: only words 4 and 8 corrupted
    do_reset(); cfg_period = 8'd4;
    for (int i = 1; i <= 9; i++)
      send(0, 0, 4'd0, 8'h01, 8'h00, 1,
           (i % 4 == 0) ? 8'h01 : 8'h00, (i % 4 == 0) ? 8'h01 : 8'h00,
           (i <= 4) ? 0 : ((i <= 8) ? 1 : 2), 0);

    // random K=3, period 0 (= every word)
    do_reset(); cfg_period = 8'd0;
    for (int i = 0; i < 1000; i++)
      send(1, 1, 4'd3, 8'h00, 8'($urandom), 0, 8'h00, 8'h00, -1, 0);

    // reset mid-BUILD: mask sequence must repeat from SEED
    do_reset(); cfg_period = 8'd1; phase = 1;
    for (int i = 0; i < 4; i++) send(1, 1, 4'd5, 8'h00, 8'(8'hF0 + i), 0, 8'h00, 8'h00, -1, 0);
    present(1, 1, 4'd5, 8'h00, 8'h99, 0, 8'h00, 8'h00, -1);
    rst_n = 1'b0; phase = 2;
    rel_reset();
    for (int i = 0; i < 4; i++) send(1, 1, 4'd5, 8'h00, 8'(8'hF0 + i), 0, 8'h00, 8'h00, -1, 0);
    phase = 0;

    fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
